led_blink_code_ctrl: RTL and testbench
======================================

# led_blink_code_ctrl

Time-shares a single board LED between up to NUM_REQ status requesters by emitting blink codes: requester i is shown as i+1 blinks followed by a dark gap. A round-robin, non-preemptive arbiter picks the next requester. An internal prescaler provides the blink time base. The block sits behind the reset synchronizer and drives the top-level `led` pin.

## Interface
- NUM_REQ, 4, number of requesters; legal range 1..16
- TICK_DIV, 12_500_000, clk cycles per blink tick (250 ms at 50 MHz); ≥1
- ON_TICKS, 1, ticks LED is lit per blink; ≥1
- OFF_TICKS, 1, ticks LED is dark between blinks of one code; ≥1
- GAP_TICKS, 4, ticks LED is dark after the last blink of a code; ≥1
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req  in  NUM_REQ  level requests; bit i asks for code i+1
- grant  out  NUM_REQ  one-hot; requester whose code is being shown; 0 when idle
- busy  out  1  high while a code is in progress
- code_done  out  1  one-cycle pulse when a code completes
- led  out  1  LED drive

## Operation
- States: IDLE, ON, OFF, GAP.
- Outputs are registered. In reset: state IDLE, grant 0, busy 0, code_done 0, led inactive, rr pointer 0, all counters 0.
- IDLE: if req is nonzero, select the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - Next cycle: state ON, grant set one-hot, busy 1, led active.
  - The blink counter loads with the number of blinks (index+1), and the prescaler and tick counter clear.
  - If req is zero, remain in IDLE.
- Prescaler counts 0..TICK_DIV-1 and produces a tick on TICK_DIV-1. The tick counter counts ticks within the current state. Both clear on every state change.
- ON lasts ON_TICKS ticks. On exit, decrement the remaining-blinks count.
  - Remaining > 0: go to OFF.
  - Otherwise: go to GAP.
- OFF lasts OFF_TICKS ticks, then returns to ON.
- GAP lasts GAP_TICKS ticks. On exit:
  - Go to IDLE; grant 0, busy 0.
  - code_done pulses for exactly that first IDLE cycle.
  - rr pointer becomes (granted index + 1) mod NUM_REQ.
- led is active in ON only, and inactive in IDLE, OFF and GAP.
- Non-preemptive: deasserting req, or new requests arriving, during a code do not alter it. The code always completes.
- Request changes while busy are ignored. Arbitration uses req as sampled on the IDLE cycle.
- rst asserted in any state returns all registers to their reset values on the next edge. No code_done pulse is generated.
- Counter widths: $clog2 of TICK_DIV, max(ON,OFF,GAP) ticks, and NUM_REQ+1, each with a minimum width of 1 bit. Counters never wrap in legal configurations.

## Timing
- Grant latency: req sampled high in IDLE, so grant, busy and led are active on the next cycle.
- A code of k blinks spans (k·ON_TICKS + (k−1)·OFF_TICKS + GAP_TICKS)·TICK_DIV cycles, measured from the first busy cycle to the last busy cycle inclusive.
- Each ON and OFF interval is exactly its tick count × TICK_DIV cycles.
- There is at least one IDLE cycle (the code_done cycle) between consecutive codes. The next grant appears no earlier than the cycle after code_done.

## Configuration
- LED_BLINK_CODE_CTRL_ACTIVE_LOW_EN defined:
  - led is driven active-low: 0 = lit, and 1 in reset, IDLE, OFF and GAP.
  - Suited to the evaluation-kit LEDs.
- Undefined:
  - led is active-high: 1 = lit, and 0 in reset and in the dark states.
- No other behaviour differs.

## Test plan
All scenarios use TICK_DIV=4, ON_TICKS=1, OFF_TICKS=1, GAP_TICKS=2, NUM_REQ=4, with the macro undefined.
- Single request: req=4'b0100 held.
  - grant=4'b0100 and busy=1 for 28 cycles.
  - led pattern is 4 high / 4 low / 4 high / 4 low / 4 high / 8 low.
  - code_done pulses once, then the code repeats after one IDLE cycle.
- Round-robin: req=4'b1001 held.
  - Codes alternate: grant 0001 (1 blink, 12 cycles), then 1000 (4 blinks, 36 cycles), then 0001.
- Non-preemption: req=4'b0001 for one cycle, then 0.
  - A full 12-cycle code completes with exactly 1 blink and one code_done pulse.
  - The block then stays IDLE with led=0.
- Mid-code reset: assert rst during the second ON of a 3-blink code.
  - Next cycle: led=0, grant=0, busy=0, no code_done.
  - After rst releases with req=4'b0010, the pattern is granted to index 1 (pointer back at 0).
- Active-low build: repeat the first scenario with LED_BLINK_CODE_CTRL_ACTIVE_LOW_EN defined.
  - led is the exact inverse of the expected pattern, and led=1 in reset.
- Idle: req=0 for 100 cycles after reset.
  - led=0, grant=0, busy=0 and code_done=0 throughout.

Source files
------------

// File: rtl/led_blink_code_ctrl_if.sv
// Request/grant and LED bundle for the blink-code controller.
// master = requester side, slave = controller side.
interface led_blink_code_ctrl_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               code_done;
    logic               led;

    modport master (
        output req,
        input  grant,
        input  busy,
        input  code_done,
        input  led
    );

    modport slave (
        input  req,
        output grant,
        output busy,
        output code_done,
        output led
    );
endinterface

// File: rtl/led_blink_code_ctrl.sv
// Shares one LED among NUM_REQ requesters as blink codes (i+1 blinks, then a gap), round-robin.
// Define LED_BLINK_CODE_CTRL_ACTIVE_LOW_EN for an active-low LED pin.
module led_blink_code_ctrl #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned ON_TICKS  = 1,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned GAP_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    led_blink_code_ctrl_if.slave  bus
);

`ifdef LED_BLINK_CODE_CTRL_ACTIVE_LOW_EN
    localparam logic LedOn = 1'b0;
`else
    localparam logic LedOn = 1'b1;
`endif

    localparam int unsigned MaxOnOff = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MaxTicks = (MaxOnOff > GAP_TICKS) ? MaxOnOff : GAP_TICKS;
    localparam int unsigned PreW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
    localparam int unsigned BlinkW   = $clog2(NUM_REQ + 1);
    localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

    state_e             r_state,  w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,  w_grant_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_done,   w_done_nxt;
    logic               r_led,    w_led_nxt;
    logic [IdxW-1:0]    r_rr,     w_rr_nxt;
    logic [IdxW-1:0]    r_idx,    w_idx_nxt;
    logic [BlinkW-1:0]  r_blinks, w_blinks_nxt;
    logic [PreW-1:0]    r_presc,  w_presc_nxt;
    logic [TickW-1:0]   r_ticks,  w_ticks_nxt;

    logic               w_any;
    logic [IdxW-1:0]    w_sel;
    logic [IdxW-1:0]    w_cand;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_tick;
    logic [TickW-1:0]   w_len_m1;
    logic               w_interval_end;

    // Round-robin pick: first set request at or above the pointer, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = IdxW'((32'(r_rr) + i) % NUM_REQ);
            if (!w_any && bus.req[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
        w_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_onehot[i] = (IdxW'(i) == w_sel);
        end
    end

    always_comb begin
        w_len_m1 = '0;
        unique case (r_state)
            StOn:    w_len_m1 = TickW'(ON_TICKS - 1);
            StOff:   w_len_m1 = TickW'(OFF_TICKS - 1);
            StGap:   w_len_m1 = TickW'(GAP_TICKS - 1);
            default: w_len_m1 = '0;
        endcase
        w_tick         = (r_presc == PreW'(TICK_DIV - 1));
        w_interval_end = w_tick && (r_ticks == w_len_m1);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_rr_nxt     = r_rr;
        w_idx_nxt    = r_idx;
        w_blinks_nxt = r_blinks;
        w_presc_nxt  = '0;
        w_ticks_nxt  = '0;
        w_led_nxt    = ~LedOn;

        if (r_state != StIdle) begin
            if (w_tick) begin
                w_ticks_nxt = r_ticks + 1'b1;
            end else begin
                w_presc_nxt = r_presc + 1'b1;
                w_ticks_nxt = r_ticks;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_nxt  = StOn;
                    w_grant_nxt  = w_onehot;
                    w_busy_nxt   = 1'b1;
                    w_idx_nxt    = w_sel;
                    w_blinks_nxt = BlinkW'(w_sel) + 1'b1;
                end
            end
            StOn: begin
                if (w_interval_end) begin
                    w_blinks_nxt = r_blinks - 1'b1;
                    w_state_nxt  = (r_blinks > BlinkW'(1)) ? StOff : StGap;
                end
            end
            StOff: begin
                if (w_interval_end) begin
                    w_state_nxt = StOn;
                end
            end
            StGap: begin
                if (w_interval_end) begin
                    w_state_nxt = StIdle;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_rr_nxt    = (r_idx == IdxW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Every state change restarts the time base.
        if (w_state_nxt != r_state) begin
            w_presc_nxt = '0;
            w_ticks_nxt = '0;
        end
        if (w_state_nxt == StOn) begin
            w_led_nxt = LedOn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_led    <= ~LedOn;
            r_rr     <= '0;
            r_idx    <= '0;
            r_blinks <= '0;
            r_presc  <= '0;
            r_ticks  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_led    <= w_led_nxt;
            r_rr     <= w_rr_nxt;
            r_idx    <= w_idx_nxt;
            r_blinks <= w_blinks_nxt;
            r_presc  <= w_presc_nxt;
            r_ticks  <= w_ticks_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign bus.code_done = r_done;
    assign bus.led       = r_led;

endmodule

// File: tb/tb_led_blink_code_ctrl.sv
// Bench for led_blink_code_ctrl: table-driven scenarios, directed corner cases and random
// requests, all checked against a pattern-queue model of the blink codes.
module tb_led_blink_code_ctrl;
    localparam int unsigned NR  = 4;
    localparam int unsigned TD  = 4;
    localparam int unsigned ONT = 1;
    localparam int unsigned OFT = 1;
    localparam int unsigned GPT = 2;

`ifdef LED_BLINK_CODE_CTRL_ACTIVE_LOW_EN
    localparam logic LedInv = 1'b1;
`else
    localparam logic LedInv = 1'b0;
`endif

    logic clk;
    logic rst;

    led_blink_code_ctrl_if #(.NUM_REQ(NR)) bus ();

    led_blink_code_ctrl #(
        .NUM_REQ  (NR),
        .TICK_DIV (TD),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFT),
        .GAP_TICKS(GPT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] g;
        logic          b;
        logic          l;
        logic          d;
    } obs_t;

    obs_t q[$];
    int   m_rr;
    int   n_total;
    int   n_bad;
    int   n_cyc;
    int   c_busy, c_lit, c_done;
    logic [NR-1:0] c_first;

    // Expected outputs for one whole code, cycle by cycle, from the blink-code rules.
    function automatic void push_code(input int idx);
        obs_t o;
        o.g = NR'(1) << idx;
        o.b = 1'b1;
        o.d = 1'b0;
        for (int k = 0; k <= idx; k++) begin
            o.l = 1'b1;
            for (int c = 0; c < int'(ONT * TD); c++) q.push_back(o);
            o.l = 1'b0;
            if (k < idx) for (int c = 0; c < int'(OFT * TD); c++) q.push_back(o);
        end
        for (int c = 0; c < int'(GPT * TD); c++) q.push_back(o);
        q.push_back('{g: '0, b: 1'b0, l: 1'b0, d: 1'b1});
    endfunction

    function automatic obs_t model_step(input logic r, input logic [NR-1:0] rq);
        obs_t e;
        e = '0;
        if (r) begin
            q.delete();
            m_rr = 0;
        end else begin
            if (q.size() == 0 && rq != 0) begin
                for (int i = 0; i < int'(NR); i++) begin
                    int j;
                    j = (m_rr + i) % int'(NR);
                    if (rq[j]) begin
                        push_code(j);
                        m_rr = (j + 1) % int'(NR);
                        break;
                    end
                end
            end
            if (q.size() != 0) e = q.pop_front();
        end
        return e;
    endfunction

    task automatic check_val(input string name, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Apply inputs for one cycle, then compare outputs at the following negedge.
    task automatic cyc(input logic r, input logic [NR-1:0] rq);
        obs_t e;
        obs_t a;
        rst     = r;
        bus.req = rq;
        e = model_step(r, rq);
        @(negedge clk);
        n_cyc++;
        a = '{g: bus.grant, b: bus.busy, l: bus.led ^ LedInv, d: bus.code_done};
        n_total++;
        if (a !== e) begin
            n_bad++;
            if (n_bad < 30)
                $display("FAIL cycle %0d: got g=%b b=%b l=%b d=%b want g=%b b=%b l=%b d=%b",
                         n_cyc, a.g, a.b, a.l, a.d, e.g, e.b, e.l, e.d);
        end
        if (a.b) c_busy++;
        if (a.l) c_lit++;
        if (a.d) c_done++;
        if (c_first == 0 && a.g != 0) c_first = a.g;
    endtask

    task automatic clr_counts();
        c_busy  = 0;
        c_lit   = 0;
        c_done  = 0;
        c_first = '0;
    endtask

    typedef struct {
        logic [NR-1:0] req;
        int            cycles;
        int            exp_busy;
        int            exp_lit;
        int            exp_done;
        logic [NR-1:0] exp_first;
    } vec_t;

    vec_t vecs[5];
    logic [NR-1:0] rq;

    initial begin
        n_total = 0;
        n_bad   = 0;
        n_cyc   = 0;
        m_rr    = 0;
        rst     = 1'b1;
        bus.req = '0;
        clr_counts();

        // Single 3-blink code repeats; 1/4-blink alternation; idle; 2 blinks; all-request.
        vecs[0] = '{4'b0100, 58, 56, 24, 2, 4'b0100};
        vecs[1] = '{4'b1001, 50, 48, 20, 2, 4'b0001};
        vecs[2] = '{4'b0000, 100, 0, 0, 0, 4'b0000};
        vecs[3] = '{4'b0010, 21, 20, 8, 1, 4'b0010};
        vecs[4] = '{4'b1111, 13, 12, 4, 1, 4'b0001};

        cyc(1'b1, '0);
        cyc(1'b1, '0);
        check_val("reset_led", int'(bus.led), int'(LedInv));
        check_val("reset_grant", int'(bus.grant), 0);
        check_val("reset_busy", int'(bus.busy), 0);
        check_val("reset_done", int'(bus.code_done), 0);

        for (int v = 0; v < 5; v++) begin
            cyc(1'b1, '0);
            cyc(1'b1, '0);
            clr_counts();
            for (int c = 0; c < vecs[v].cycles; c++) cyc(1'b0, vecs[v].req);
            check_val($sformatf("vec%0d_busy", v), c_busy, vecs[v].exp_busy);
            check_val($sformatf("vec%0d_lit", v), c_lit, vecs[v].exp_lit);
            check_val($sformatf("vec%0d_done", v), c_done, vecs[v].exp_done);
            check_val($sformatf("vec%0d_first", v), int'(c_first), int'(vecs[v].exp_first));
        end

        // Non-preemption: one-cycle request still produces a full code.
        cyc(1'b1, '0);
        clr_counts();
        cyc(1'b0, 4'b0001);
        for (int c = 0; c < 30; c++) cyc(1'b0, '0);
        check_val("np_busy", c_busy, 12);
        check_val("np_lit", c_lit, 4);
        check_val("np_done", c_done, 1);
        check_val("np_idle_led", int'(bus.led), int'(LedInv));

        // Reset during the second ON of a 3-blink code.
        cyc(1'b1, '0);
        clr_counts();
        for (int c = 0; c < 10; c++) cyc(1'b0, 4'b0100);
        check_val("mid_on_led", int'(bus.led ^ LedInv), 1);
        cyc(1'b1, 4'b0100);
        check_val("mid_rst_led", int'(bus.led), int'(LedInv));
        check_val("mid_rst_grant", int'(bus.grant), 0);
        check_val("mid_rst_busy", int'(bus.busy), 0);
        check_val("mid_rst_done", int'(bus.code_done), 0);
        clr_counts();
        cyc(1'b0, 4'b0010);
        check_val("post_rst_grant", int'(bus.grant), 2);
        for (int c = 0; c < 25; c++) cyc(1'b0, '0);
        check_val("post_rst_done", c_done, 1);

        // Random requests with occasional resets, checked every cycle by the model.
        rq = '0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 7) == 0) rq = NR'($urandom_range(0, 15));
            cyc(($urandom_range(0, 299) == 0), rq);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
